// File: rtl/sc_mac_pkg.sv
// Shared types and helpers for the stochastic-computing MAC datapath.
package sc_mac_pkg;

    typedef enum logic [1:0] {
        MODE_OR  = 2'd0,
        MODE_MUX = 2'd1,
        MODE_CNT = 2'd2
    } mac_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } mac_state_e;

    localparam int unsigned MAX_WIDTH = 32;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_WIDTH-1:0] bitrev(input logic [MAX_WIDTH-1:0] v,
                                                    input int unsigned w);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_popcount.sv
// Combinational ones-count over an N-bit lane vector.
module sc_popcount #(
    parameter int unsigned N     = 16,
    parameter int unsigned OUT_W = $clog2(N) + 1
) (
    input  logic [N-1:0]     bits,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count = count + OUT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/gain_mac_uni_param.sv
// Parametrised unipolar stochastic MAC: per-lane AND multiply of low-discrepancy
// streams, run-time selected reduction, accumulated over one full stream period.
module gain_mac_uni_param
    import sc_mac_pkg::*;
#(
    parameter int unsigned  LANES = 16,
    parameter int unsigned  WIDTH = 8,
    localparam int unsigned ACC_W = WIDTH + $clog2(LANES) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [LANES-1:0][WIDTH-1:0] iA,
    input  logic [LANES-1:0][WIDTH-1:0] iB,
    output logic                        busy,
    output logic                        oC,
    output logic                        oC_valid,
    output logic [ACC_W-1:0]            res,
    output logic                        res_valid,
    input  logic                        res_ready
);

    localparam int unsigned SEL_W = $clog2(LANES);
    localparam int unsigned CNT_W = $clog2(LANES) + 1;

    mac_state_e                  state;
    mac_mode_e                   modeQ;
    logic [WIDTH-1:0]            cnt;
    logic [ACC_W-1:0]            acc;
    logic [LANES-1:0][WIDTH-1:0] opA;
    logic [LANES-1:0][WIDTH-1:0] opB;
    logic                        resValidQ;

    logic [WIDTH-1:0] rngA;
    logic [LANES-1:0] prod;
    logic [CNT_W-1:0] popCount;
    logic             redBit;
    logic [ACC_W-1:0] addend;

    always_comb begin
        rngA = WIDTH'(bitrev(MAX_WIDTH'(cnt), WIDTH));
        prod = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            prod[i] = (opA[i] > rngA) && (opB[i] > cnt);
        end
    end

    sc_popcount #(
        .N     (LANES),
        .OUT_W (CNT_W)
    ) popcountInst (
        .bits  (prod),
        .count (popCount)
    );

    always_comb begin
        redBit = (modeQ == MODE_MUX) ? prod[cnt[SEL_W-1:0]] : |prod;
        addend = (modeQ == MODE_CNT) ? ACC_W'(popCount) : ACC_W'(redBit);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= S_IDLE;
            modeQ     <= MODE_OR;
            cnt       <= '0;
            acc       <= '0;
            opA       <= '0;
            opB       <= '0;
            resValidQ <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opA <= iA;
                        opB <= iB;
                        case (mode)
                            2'd0:    modeQ <= MODE_OR;
                            2'd1:    modeQ <= MODE_MUX;
                            default: modeQ <= MODE_CNT;
                        endcase
                        cnt   <= '0;
                        acc   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc + addend;
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state     <= S_DONE;
                        resValidQ <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        resValidQ <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign oC        = (state == S_RUN) && redBit;
    assign oC_valid  = (state == S_RUN);
    assign busy      = (state != S_IDLE) && !resValidQ;
    assign res       = acc;
    assign res_valid = resValidQ;

endmodule
